// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiplication is radix-2 shift-add, division is restoring. Both work on
// operand magnitudes, with the result signs fixed up in a single FIX cycle.
//
// Optional feature macro: MDU_DIV_EN
//   defined   -> DIV (op 010) and DIVU (op 011) are implemented.
//   undefined -> no divider datapath. Ops 010/011 are ignored like illegal
//                ops, and div_by_zero is tied low.
//
// Parameters
//   WIDTH        operand / HI / LO width, 8..64 (default 32)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while busy = 0
//   op[2:0]      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                110/111 ignored
//   A            multiplicand / dividend / MTHI-MTLO source
//   B            multiplier / divisor
//   busy         FSM is not in IDLE
//   done         one-cycle pulse: hi/lo hold a new MULT/DIV result
//   div_by_zero  set with done for a division by zero, held until the next
//                accepted start
//   hi, lo       HI (product upper half / remainder) and
//                LO (product lower half / quotient)
//
// Handshake: a request is accepted at a rising edge where start = 1 and the
// FSM is IDLE (busy = 0). op/A/B are captured at that edge only. start while
// busy = 1 is dropped, never queued. A new request may be accepted in the
// same cycle that done is high.
//
// Debug: the FSM state is held in the enum signal 'state'.
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  // acc_hi/acc_lo: multiply -> partial product / remaining multiplier bits,
  //                divide   -> partial remainder / dividend shifting into quotient.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  // opnd: multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0] opnd;
  logic             neg_lo;   // negate product / quotient at FIX

  // Request decode
  logic             is_mul_op;
  logic             is_div_op;
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Shift-add step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);

`ifdef MDU_DIV_EN
  logic             k_mul;    // 1: multiply in flight, 0: divide in flight
  logic             k_div0;   // divide with zero divisor in flight
  logic             neg_hi;   // negate remainder at FIX
  logic             dbz;

  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. The remainder stays below the
  // divisor, so the low WIDTH bits of the difference are exact.
  assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, opnd});
  assign div_rem = div_sh[WIDTH-1:0] - opnd;

  assign q_fix = neg_lo ? -acc_lo : acc_lo;
  assign r_fix = neg_hi ? -acc_hi : acc_hi;

  assign div_by_zero = dbz;
`else
  assign is_div_op   = 1'b0;
  assign signed_op   = (op == OP_MULT);
  assign div_by_zero = 1'b0;
`endif

  // Magnitudes. The most negative value maps onto itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign a_neg = signed_op & A[WIDTH-1];
  assign b_neg = signed_op & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // Add the multiplicand when the current multiplier bit is set. The carry is
  // kept and shifted down into acc_hi together with the rest of the sum.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_lo ? -prod : prod;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
`ifdef MDU_DIV_EN
      k_mul  <= 1'b0;
      k_div0 <= 1'b0;
      neg_hi <= 1'b0;
      dbz    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_op) begin
              state  <= CALC;
              cnt    <= '0;
              opnd   <= a_mag;
              acc_hi <= '0;
              acc_lo <= b_mag;
              neg_lo <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
              k_mul  <= 1'b1;
              k_div0 <= 1'b0;
              neg_hi <= 1'b0;
              dbz    <= 1'b0;
`endif
            end
`ifdef MDU_DIV_EN
            else if (is_div_op) begin
              state <= CALC;
              cnt   <= '0;
              opnd  <= b_mag;
              k_mul <= 1'b0;
              dbz   <= 1'b0;
              if (B == '0) begin
                // Preload the zero-divisor result. CALC leaves on its first
                // edge and FIX copies it out unchanged.
                k_div0 <= 1'b1;
                acc_hi <= A;
                acc_lo <= '1;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
              end else begin
                k_div0 <= 1'b0;
                acc_hi <= '0;
                acc_lo <= a_mag;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
              end
            end
`endif
            else if (op == OP_MTHI) begin
              hi <= A;
`ifdef MDU_DIV_EN
              dbz <= 1'b0;
`endif
            end else if (op == OP_MTLO) begin
              lo <= A;
`ifdef MDU_DIV_EN
              dbz <= 1'b0;
`endif
            end
            // Remaining opcodes are ignored entirely.
          end
        end

        CALC: begin
`ifdef MDU_DIV_EN
          if (k_div0) begin
            state <= FIX;
          end else begin
            if (k_mul) begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end else begin
              acc_hi <= div_ge ? div_rem : div_sh[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= FIX;
          end
`else
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
`endif
        end

        FIX: begin
`ifdef MDU_DIV_EN
          if (k_mul) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          dbz <= k_div0;
`else
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
`endif
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Bench for mul_div_unit (WIDTH = 32). Results of MULT/MULTU (and DIV/DIVU
// when MDU_DIV_EN is defined) are predicted by a reference model and queued
// when the request is driven. A monitor pops and compares on every done
// pulse. Scenario tasks add inline checks of latency, busy, hi/lo stability,
// flag behaviour and reset.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam int W = 32;

`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .A           (a),
    .B           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // ---------------- scoreboard ----------------
  int             n_cmp = 0;
  int             n_err = 0;
  logic [2*W:0]   exp_q[$];   // {div_by_zero, hi, lo}
  logic [2*W:0]   mon_e;

  function automatic bit is_result_op(input logic [2:0] o);
    return (o == 3'b000) || (o == 3'b001) || (DIV_ON && (o == 3'b010 || o == 3'b011));
  endfunction

  function automatic logic [2*W:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy, sq, sr;
    logic [2*W-1:0] p;
    sx = (o == 3'b000 || o == 3'b010) ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    sy = (o == 3'b000 || o == 3'b010) ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    if (o == 3'b000 || o == 3'b001) begin
      p = sx * sy;
      return {1'b0, p};
    end
    if (y == '0) return {1'b1, x, {W{1'b1}}};
    sq = sx / sy;
    sr = sx % sy;
    return {1'b0, sr[W-1:0], sq[W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: hi=%h lo=%h dbz=%b, no result expected", hi, lo, div_by_zero);
      end else begin
        mon_e = exp_q.pop_front();
        if ({div_by_zero, hi, lo} !== mon_e) begin
          n_err++;
          $display("FAIL result: got dbz=%b hi=%h lo=%h, expected dbz=%b hi=%h lo=%h",
                   div_by_zero, hi, lo, mon_e[2*W], mon_e[2*W-1:W], mon_e[W-1:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Present a request and return #1 after the edge that samples it.
  task automatic accept_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int g;
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, g);
    end
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    if (is_result_op(o)) exp_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;   // later input changes must not matter
    b = $urandom;
  endtask

  // Wait for done, measuring latency/busy and checking hi/lo stay put.
  // With poke set, a start pulse (MTHI) is driven while busy.
  task automatic wait_done(input bit poke, output int lat, output int busy_cyc);
    logic [W-1:0] ph, pl;
    bit stable;
    ph = hi;
    pl = lo;
    stable = 1'b1;
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && lat < 200) begin
      if (poke && lat == 5) begin
        start = 1'b1;
        op = 3'b100;
        a = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cyc++;
      if (!done && (hi !== ph || lo !== pl)) stable = 1'b0;
    end
    start = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
    n_cmp++;
    if (!stable) begin
      n_err++;
      $display("FAIL hi_lo_stable: hi/lo changed before done, required stable");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
    n_cmp++;
    if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b required 0", div_by_zero); end
    n_cmp++;
    if (hi !== '0) begin n_err++; $display("FAIL reset_hi: got %h required 0", hi); end
    n_cmp++;
    if (lo !== '0) begin n_err++; $display("FAIL reset_lo: got %h required 0", lo); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    int lat, bc;
    accept_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(1'b0, lat, bc);
    n_cmp++;
    if (lat != 33) begin n_err++; $display("FAIL mult_latency: got %0d required 33", lat); end
    n_cmp++;
    if (bc != 33) begin n_err++; $display("FAIL mult_busy_cycles: got %0d required 33", bc); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_at_done: got %b required 0", busy); end
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_err++; $display("FAIL mult_value: got %h_%h required ffffffff_fffffffa", hi, lo);
    end
    // Unsigned square with an ignored start pulse while busy
    accept_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b1, lat, bc);
    n_cmp++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_err++; $display("FAIL multu_value: got %h_%h required fffffffe_00000001", hi, lo);
    end
    // Signed corner patterns (scoreboard checks)
    accept_op(3'b000, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(1'b0, lat, bc);
    accept_op(3'b000, 32'h8000_0000, 32'h8000_0000); wait_done(1'b0, lat, bc);
    accept_op(3'b000, 32'h0000_0000, 32'h1234_5678); wait_done(1'b0, lat, bc);
    accept_op(3'b001, 32'h8000_0001, 32'h7FFF_FFFF); wait_done(1'b0, lat, bc);
  endtask

  task automatic test_mt();
    logic [W-1:0] ph, pl;
    ph = hi;
    pl = lo;
    accept_op(3'b100, 32'h1234_5678, 32'h0);
    n_cmp++;
    if (hi !== 32'h1234_5678 || lo !== pl || busy !== 1'b0) begin
      n_err++; $display("FAIL mthi: got hi=%h lo=%h busy=%b required hi=12345678 lo=%h busy=0", hi, lo, busy, pl);
    end
    accept_op(3'b101, 32'h9ABC_DEF0, 32'h0);
    n_cmp++;
    if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      n_err++; $display("FAIL mtlo: got hi=%h lo=%h busy=%b required hi=12345678 lo=9abcdef0 busy=0", hi, lo, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (hi === ph && lo === pl) begin
      n_err++; $display("FAIL mt_effect: hi/lo unchanged at %h_%h", hi, lo);
    end
  endtask

  // Ops that must leave everything untouched
  task automatic check_ignored(input logic [2:0] o, input string tag);
    logic [W-1:0] ph, pl;
    logic pz;
    bit seen_busy;
    ph = hi;
    pl = lo;
    pz = div_by_zero;
    seen_busy = 1'b0;
    accept_op(o, 32'd9, 32'd3);
    for (int i = 0; i < 4; i++) begin
      if (busy) seen_busy = 1'b1;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (seen_busy || hi !== ph || lo !== pl || div_by_zero !== pz) begin
      n_err++;
      $display("FAIL %s: busy_seen=%b hi=%h lo=%h dbz=%b required 0 %h %h %b",
               tag, seen_busy, hi, lo, div_by_zero, ph, pl, pz);
    end
  endtask

  task automatic test_illegal();
    check_ignored(3'b110, "illegal_110");
    check_ignored(3'b111, "illegal_111");
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    int lat, bc;
    accept_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(1'b0, lat, bc);
    n_cmp++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL div_value: got hi=%h lo=%h required ffffffff fffffffd", hi, lo);
    end
    accept_op(3'b011, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(1'b0, lat, bc);
    n_cmp++;
    if (lo !== 32'h7FFF_FFFC || hi !== 32'h0000_0001) begin
      n_err++; $display("FAIL divu_value: got hi=%h lo=%h required 00000001 7ffffffc", hi, lo);
    end
    accept_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, lat, bc);
    n_cmp++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0 || div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL div_overflow: got hi=%h lo=%h dbz=%b required 0 80000000 0", hi, lo, div_by_zero);
    end
    // Divide by zero
    accept_op(3'b010, 32'd5, 32'd0);
    wait_done(1'b0, lat, bc);
    n_cmp++;
    if (lat != 2) begin n_err++; $display("FAIL div0_latency: got %0d required 2", lat); end
    n_cmp++;
    if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF || div_by_zero !== 1'b1) begin
      n_err++; $display("FAIL div0_value: got hi=%h lo=%h dbz=%b required 5 ffffffff 1", hi, lo, div_by_zero);
    end
    check_ignored(3'b111, "div0_flag_hold");
    accept_op(3'b101, 32'd7, 32'd0);
    n_cmp++;
    if (lo !== 32'd7 || div_by_zero !== 1'b0 || hi !== 32'd5) begin
      n_err++; $display("FAIL mtlo_clear: got hi=%h lo=%h dbz=%b required 5 7 0", hi, lo, div_by_zero);
    end
    accept_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0000); wait_done(1'b0, lat, bc);
    accept_op(3'b011, 32'd100, 32'd7);               wait_done(1'b0, lat, bc);
    n_cmp++;
    if (div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL dbz_cleared_by_start: got %b required 0", div_by_zero);
    end
  endtask
`else
  task automatic test_div_disabled();
    check_ignored(3'b010, "div_disabled");
    check_ignored(3'b011, "divu_disabled");
  endtask
`endif

  task automatic test_reset_mid();
    int lat, bc;
    accept_op(3'b000, 32'h1357_9BDF, 32'h2468_ACE0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b required all 0", hi, lo, busy, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_abort: got hi=%h lo=%h busy=%b required 0 0 0", hi, lo, busy);
    end
    accept_op(3'b000, 32'd6, 32'd7);
    wait_done(1'b0, lat, bc);
    n_cmp++;
    if (lo !== 32'd42 || hi !== 32'd0) begin
      n_err++; $display("FAIL post_reset_mult: got hi=%h lo=%h required 0 2a", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [2:0] o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = DIV_ON ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      if (!DIV_ON && y == 32'd0) y = 32'd3;
      accept_op(o, x, y);
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++; $display("FAIL b2b_accept %0d: busy=%b required 1", i, busy);
      end
      wait_done(1'b0, lat, bc);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    test_reset();
    test_mult();
    test_mt();
    test_illegal();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL pending_results: %0d left in queue, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
